// File: rtl/gcd_datapath_if.sv
`default_nettype none
// ============================================================================
// Module   : gcd_datapath_if
// Purpose  : Operand, FSM-flag and status/result bundle between the GCD
//            control FSM (master) and the GCD datapath (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface gcd_datapath_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] operand_a_i;
  logic [WIDTH-1:0] operand_b_i;
  logic             load_i;
  logic             flag_init_i;
  logic             flag_compute_i;
  logic             flag_finish_i;
  logic             compute_enable_o;
  logic             compare_zero_o;
  logic [WIDTH-1:0] result_o;
  logic             result_valid_o;
  logic [WIDTH-1:0] iter_count_o;

  // Control side: supplies operands and state flags, observes status/result.
  modport master (
    output operand_a_i, operand_b_i, load_i,
    output flag_init_i, flag_compute_i, flag_finish_i,
    input  compute_enable_o, compare_zero_o,
    input  result_o, result_valid_o, iter_count_o
  );

  // Datapath side.
  modport slave (
    input  operand_a_i, operand_b_i, load_i,
    input  flag_init_i, flag_compute_i, flag_finish_i,
    output compute_enable_o, compare_zero_o,
    output result_o, result_valid_o, iter_count_o
  );

endinterface
`default_nettype wire

// File: rtl/gcd_datapath.sv
`default_nettype none
// ============================================================================
// Module   : gcd_datapath
// Purpose  : Operand/arithmetic stage of a subtraction-based GCD engine.
//            Captures two operands, reports zero/non-zero status to the
//            control FSM, runs one Euclid subtraction per COMPUTE cycle and
//            registers the result in FINISH.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_datapath #(
  parameter int WIDTH = 16
) (
  input  wire logic          clk_i,
  input  wire logic          reset_i,
  gcd_datapath_if.slave      bus
);

  localparam logic [WIDTH-1:0] C_ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_ZERO     = '0;
  localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             loaded_q;
  logic [WIDTH-1:0] result_q;
  logic             result_valid_q;
  logic [WIDTH-1:0] iter_count_q;

  logic             a_zero;
  logic             b_zero;
  logic             compare_zero;
  logic             compute_enable;
  logic             a_ge_b;

  // Operand status seen by the FSM; both stay low until operands are loaded.
  always_comb begin
    a_zero         = (a_q == C_ZERO);
    b_zero         = (b_q == C_ZERO);
    compare_zero   = loaded_q & (a_zero | b_zero);
    compute_enable = loaded_q & ~a_zero & ~b_zero;
    a_ge_b         = (a_q >= b_q);
  end

  // Operand capture, Euclid step and result register; flags are decoded
  // with init > compute > finish priority so illegal combinations are benign.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_q            <= C_ZERO;
      b_q            <= C_ZERO;
      loaded_q       <= 1'b0;
      result_q       <= C_ZERO;
      result_valid_q <= 1'b0;
      iter_count_q   <= C_ZERO;
    end else if (bus.flag_init_i) begin
      if (bus.load_i) begin
        a_q            <= bus.operand_a_i;
        b_q            <= bus.operand_b_i;
        loaded_q       <= 1'b1;
        iter_count_q   <= C_ZERO;
        result_valid_q <= 1'b0;
      end
    end else if (bus.flag_compute_i) begin
      // Once either operand hits zero the pair is frozen.
      if (compute_enable) begin
        if (a_ge_b) begin
          a_q <= a_q - b_q;
        end else begin
          b_q <= b_q - a_q;
        end
        if (iter_count_q != C_ALL_ONES) begin
          iter_count_q <= iter_count_q + C_ONE;
        end
      end
    end else if (bus.flag_finish_i) begin
      if (loaded_q) begin
        // One operand is zero here, so OR selects the surviving value.
        result_q       <= a_q | b_q;
        result_valid_q <= 1'b1;
      end
    end
  end

  assign bus.compare_zero_o   = compare_zero;
  assign bus.compute_enable_o = compute_enable;
  assign bus.result_o         = result_q;
  assign bus.result_valid_o   = result_valid_q;
  assign bus.iter_count_o     = iter_count_q;

endmodule
`default_nettype wire
